// File: rtl/axis_link_traffic_gen_chk_pkg.sv
// -----------------------------------------------------------------------------
// axis_link_traffic_gen_chk_pkg
// Shared definitions for the AXIS link traffic generator/checker:
//   - pattern mode encodings
//   - PRBS polynomial and seed
//   - generator FSM state enum
//   - one-step Galois LFSR helper
// -----------------------------------------------------------------------------
package axis_link_traffic_gen_chk_pkg;

    typedef enum logic {
        MODE_INC  = 1'b0,
        MODE_PRBS = 1'b1
    } mode_e;

    localparam logic [31:0] PRBS_POLY = 32'h8020_0003;
    localparam logic [31:0] PRBS_SEED = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } gen_state_e;

    // Right-shifting Galois LFSR: the bit shifted out selects the tap XOR.
    function automatic logic [31:0] prbs_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? PRBS_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/axis_link_traffic_gen_chk_pattern_model.sv
// -----------------------------------------------------------------------------
// axis_pattern_model
// Pattern source shared by the TX generator and the RX checker.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_seed         : reload seed and sample i_mode (has priority over advance)
//   i_mode         : 0 = incrementing, 1 = PRBS
//   i_advance      : step the pattern by one word
//   o_word         : current pattern word
// -----------------------------------------------------------------------------
module axis_pattern_model
    import axis_link_traffic_gen_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_seed,
    input  logic                  i_mode,
    input  logic                  i_advance,
    output logic [DATA_WIDTH-1:0] o_word
);

    localparam int unsigned REP = (DATA_WIDTH + 31) / 32;

    mode_e                 r_mode;
    logic [DATA_WIDTH-1:0] r_cnt;
    logic [31:0]           r_lfsr;
    logic [REP*32-1:0]     w_rep;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode <= MODE_INC;
            r_cnt  <= '0;
            r_lfsr <= PRBS_SEED;
        end else if (i_seed) begin
            r_mode <= mode_e'(i_mode);
            r_cnt  <= '0;
            r_lfsr <= PRBS_SEED;
        end else if (i_advance) begin
            r_cnt  <= r_cnt + 1'b1;
            r_lfsr <= prbs_step(r_lfsr);
        end
    end

    // PRBS word is the 32-bit state replicated, then truncated to the bus.
    assign w_rep = {REP{r_lfsr}};

    always_comb begin
        o_word = r_cnt;
        if (r_mode == MODE_PRBS) begin
            o_word = w_rep[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/axis_link_traffic_gen_chk.sv
// -----------------------------------------------------------------------------
// axis_link_traffic_gen_chk
// Single-channel AXI4-Stream traffic generator and loopback checker.
// Ports:
//   sys_clk_i, rst_n_i      : channel user clock, async active-low reset
//   start_en_i, mode_i      : generation enable, pattern select
//   frame_len_i             : beats per frame (0 treated as 1)
//   clr_cnt_i               : synchronous clear of counters and error flag
//   channel_up, lane_up     : link status
//   s_axi_tx_*              : generated TX stream
//   m_axi_rx_*              : received stream (no ready)
//   tx/rx_frame_cnt_o       : saturating frame counters
//   err_cnt_o, err_flag_o   : saturating error counter, sticky error flag
//   busy_o                  : generator not idle
// -----------------------------------------------------------------------------
module axis_link_traffic_gen_chk
    import axis_link_traffic_gen_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32,
    parameter int GAP_CYCLES = 4
) (
    input  logic                    sys_clk_i,
    input  logic                    rst_n_i,
    input  logic                    start_en_i,
    input  logic                    mode_i,
    input  logic [LEN_WIDTH-1:0]    frame_len_i,
    input  logic                    clr_cnt_i,
    input  logic                    channel_up,
    input  logic                    lane_up,
    output logic [DATA_WIDTH-1:0]   s_axi_tx_tdata,
    output logic [DATA_WIDTH/8-1:0] s_axi_tx_tkeep,
    output logic                    s_axi_tx_tlast,
    output logic                    s_axi_tx_tvalid,
    input  logic                    s_axi_tx_tready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rx_tdata,
    input  logic [DATA_WIDTH/8-1:0] m_axi_rx_tkeep,
    input  logic                    m_axi_rx_tlast,
    input  logic                    m_axi_rx_tvalid,
    output logic [CNT_WIDTH-1:0]    tx_frame_cnt_o,
    output logic [CNT_WIDTH-1:0]    rx_frame_cnt_o,
    output logic [CNT_WIDTH-1:0]    err_cnt_o,
    output logic                    err_flag_o,
    output logic                    busy_o
);

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    gen_state_e            r_state, w_state_nxt;
    logic [LEN_WIDTH-1:0]  r_len, r_beat, w_len_in;
    logic [7:0]            r_gap;
    logic                  w_link_ok, w_tx_hs, w_tx_last, w_load, w_beat_inc;

    logic                  r_rx_in_frame;
    logic [LEN_WIDTH-1:0]  r_rx_len, r_rx_beat, w_rx_len, w_rx_idx;
    logic                  w_rx_last_exp, w_rx_err;
    logic [DATA_WIDTH-1:0] w_tx_word, w_rx_word;

    logic [CNT_WIDTH-1:0]  r_tx_cnt, r_rx_cnt, r_err_cnt;
    logic                  r_err_flag;

    assign w_link_ok = channel_up & lane_up;
    assign w_len_in  = (frame_len_i == '0) ? LEN_WIDTH'(1) : frame_len_i;

    // ---------------- generator ----------------
    assign s_axi_tx_tvalid = (r_state == ST_SEND);
    assign w_tx_last       = (r_beat == r_len - 1'b1);
    assign s_axi_tx_tlast  = s_axi_tx_tvalid & w_tx_last;
    assign s_axi_tx_tkeep  = '1;
    assign s_axi_tx_tdata  = w_tx_word;
    assign w_tx_hs         = s_axi_tx_tvalid & s_axi_tx_tready;
    assign busy_o          = (r_state != ST_IDLE);

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_beat_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_en_i && w_link_ok) begin
                    w_state_nxt = ST_SEND;
                    w_load      = 1'b1;
                end
            end
            ST_SEND: begin
                if (!w_link_ok) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tx_hs) begin
                    if (!w_tx_last) begin
                        w_beat_inc = 1'b1;
                    end else if (GAP_CYCLES != 0) begin
                        w_state_nxt = ST_GAP;
                    end else if (start_en_i) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (!w_link_ok) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_gap == GAP_LAST) begin
                    if (start_en_i) begin
                        w_state_nxt = ST_SEND;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_len  <= LEN_WIDTH'(1);
            r_beat <= '0;
            r_gap  <= '0;
        end else begin
            if (w_load) begin
                r_len  <= w_len_in;
                r_beat <= '0;
            end else if (w_beat_inc) begin
                r_beat <= r_beat + 1'b1;
            end
            r_gap <= (r_state == ST_GAP) ? r_gap + 1'b1 : '0;
        end
    end

    axis_pattern_model #(.DATA_WIDTH(DATA_WIDTH)) u_tx_model (
        .i_clk     (sys_clk_i),
        .i_rst_n   (rst_n_i),
        .i_seed    (~channel_up),
        .i_mode    (mode_i),
        .i_advance (w_tx_hs),
        .o_word    (w_tx_word)
    );

    // ---------------- checker ----------------
    axis_pattern_model #(.DATA_WIDTH(DATA_WIDTH)) u_rx_model (
        .i_clk     (sys_clk_i),
        .i_rst_n   (rst_n_i),
        .i_seed    (~channel_up),
        .i_mode    (mode_i),
        .i_advance (m_axi_rx_tvalid),
        .o_word    (w_rx_word)
    );

    // RX framing follows the beat count, so a stray early tlast costs
    // exactly one error and does not shift the following frame.
    assign w_rx_len      = r_rx_in_frame ? r_rx_len  : w_len_in;
    assign w_rx_idx      = r_rx_in_frame ? r_rx_beat : '0;
    assign w_rx_last_exp = (w_rx_idx == w_rx_len - 1'b1);
    assign w_rx_err      = m_axi_rx_tvalid &
                           ((m_axi_rx_tdata != w_rx_word) ||
                            (m_axi_rx_tkeep != '1) ||
                            (m_axi_rx_tlast != w_rx_last_exp));

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rx_in_frame <= 1'b0;
            r_rx_len      <= LEN_WIDTH'(1);
            r_rx_beat     <= '0;
        end else if (!channel_up) begin
            r_rx_in_frame <= 1'b0;
        end else if (m_axi_rx_tvalid) begin
            r_rx_in_frame <= ~w_rx_last_exp;
            r_rx_len      <= w_rx_len;
            r_rx_beat     <= w_rx_idx + 1'b1;
        end
    end

    // ---------------- statistics ----------------
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tx_cnt   <= '0;
            r_rx_cnt   <= '0;
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
        end else if (clr_cnt_i) begin
            r_tx_cnt   <= '0;
            r_rx_cnt   <= '0;
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
        end else begin
            if (w_tx_hs && s_axi_tx_tlast && (r_tx_cnt != '1))
                r_tx_cnt <= r_tx_cnt + 1'b1;
            if (m_axi_rx_tvalid && m_axi_rx_tlast && (r_rx_cnt != '1))
                r_rx_cnt <= r_rx_cnt + 1'b1;
            if (w_rx_err && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + 1'b1;
            if (w_rx_err)
                r_err_flag <= 1'b1;
        end
    end

    assign tx_frame_cnt_o = r_tx_cnt;
    assign rx_frame_cnt_o = r_rx_cnt;
    assign err_cnt_o      = r_err_cnt;
    assign err_flag_o     = r_err_flag;

endmodule

// File: tb/tb_axis_link_traffic_gen_chk.sv
// -----------------------------------------------------------------------------
// tb_axis_link_traffic_gen_chk
// Directed bench: TX looped back to RX with optional single-beat data
// corruption or forced tlast, expected values hand-derived.
// -----------------------------------------------------------------------------
module tb_axis_link_traffic_gen_chk;

    localparam int DW  = 32;
    localparam int LW  = 16;
    localparam int CW  = 4;
    localparam int GAP = 4;

    logic          clk = 1'b0;
    logic          rst_n, start_en, mode, clr, ch_up, ln_up, tx_tready;
    logic [LW-1:0] frame_len;
    logic [DW-1:0] tx_tdata, rx_tdata;
    logic [3:0]    tx_tkeep, rx_tkeep;
    logic          tx_tlast, tx_tvalid, rx_tlast, rx_tvalid;
    logic [CW-1:0] tx_cnt, rx_cnt, err_cnt;
    logic          err_flag, busy;

    int total = 0;
    int bad   = 0;
    int rx_n;
    int flip_at  = 999;
    int early_at = 999;

    always #5 clk = ~clk;

    // RX beat index since link-up, used to pick the beat to corrupt.
    always @(posedge clk) begin
        if (!ch_up)         rx_n <= 0;
        else if (rx_tvalid) rx_n <= rx_n + 1;
    end

    assign rx_tvalid = tx_tvalid & tx_tready;
    assign rx_tdata  = tx_tdata ^ ((rx_n == flip_at) ? 32'h1 : 32'h0);
    assign rx_tlast  = tx_tlast | (rx_n == early_at);
    assign rx_tkeep  = tx_tkeep;

    axis_link_traffic_gen_chk #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .CNT_WIDTH  (CW),
        .GAP_CYCLES (GAP)
    ) dut (
        .sys_clk_i       (clk),
        .rst_n_i         (rst_n),
        .start_en_i      (start_en),
        .mode_i          (mode),
        .frame_len_i     (frame_len),
        .clr_cnt_i       (clr),
        .channel_up      (ch_up),
        .lane_up         (ln_up),
        .s_axi_tx_tdata  (tx_tdata),
        .s_axi_tx_tkeep  (tx_tkeep),
        .s_axi_tx_tlast  (tx_tlast),
        .s_axi_tx_tvalid (tx_tvalid),
        .s_axi_tx_tready (tx_tready),
        .m_axi_rx_tdata  (rx_tdata),
        .m_axi_rx_tkeep  (rx_tkeep),
        .m_axi_rx_tlast  (rx_tlast),
        .m_axi_rx_tvalid (rx_tvalid),
        .tx_frame_cnt_o  (tx_cnt),
        .rx_frame_cnt_o  (rx_cnt),
        .err_cnt_o       (err_cnt),
        .err_flag_o      (err_flag),
        .busy_o          (busy)
    );

    function automatic logic [31:0] prbs_nx(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a TX handshake, check the beat, then step past it.
    task automatic tx_beat(input logic [31:0] d, input logic l, input string tag);
        int unsigned n;
        n = 0;
        while (!(tx_tvalid && tx_tready) && n < 32) begin
            tick();
            n++;
        end
        chk({tag, "_hs"},   32'(tx_tvalid & tx_tready), 32'd1);
        chk({tag, "_data"}, tx_tdata, d);
        chk({tag, "_last"}, 32'(tx_tlast), 32'(l));
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    // Link down for two cycles: reseeds both models and samples mode.
    task automatic relink(input logic m, input logic [LW-1:0] len);
        ch_up     = 1'b0;
        mode      = m;
        frame_len = len;
        clr       = 1'b1;
        tick();
        tick();
        clr   = 1'b0;
        ch_up = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_d;
        int          hs_n;

        rst_n = 1'b0; start_en = 1'b0; mode = 1'b0; clr = 1'b0;
        ch_up = 1'b0; ln_up = 1'b0; tx_tready = 1'b1; frame_len = 16'd4;
        repeat (3) tick();

        // reset state
        chk("rst_tvalid", 32'(tx_tvalid), 32'd0);
        chk("rst_tkeep",  32'(tx_tkeep),  32'hF);
        chk("rst_tdata",  tx_tdata,       32'd0);
        chk("rst_tlast",  32'(tx_tlast),  32'd0);
        chk("rst_txcnt",  32'(tx_cnt),    32'd0);
        chk("rst_rxcnt",  32'(rx_cnt),    32'd0);
        chk("rst_err",    32'(err_cnt),   32'd0);
        chk("rst_flag",   32'(err_flag),  32'd0);
        chk("rst_busy",   32'(busy),      32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // incrementing frames, len 4, gap 4
        ch_up = 1'b1; ln_up = 1'b1;
        tick();
        start_en = 1'b1;
        chk("pre_start", 32'(tx_tvalid), 32'd0);
        tick();
        chk("tv_rise", 32'(tx_tvalid), 32'd1);
        chk("busy_on", 32'(busy), 32'd1);
        tx_beat(0, 1'b0, "inc0");
        tx_beat(1, 1'b0, "inc1");
        tx_beat(2, 1'b0, "inc2");
        tx_beat(3, 1'b1, "inc3");
        chk("inc_txcnt1", 32'(tx_cnt), 32'd1);
        chk("inc_rxcnt1", 32'(rx_cnt), 32'd1);
        for (int i = 0; i < GAP; i++) begin
            chk("gap_idle", 32'(tx_tvalid), 32'd0);
            tick();
        end
        chk("gap_end", 32'(tx_tvalid), 32'd1);
        tx_beat(4, 1'b0, "inc4");
        start_en = 1'b0;
        tx_beat(5, 1'b0, "inc5");
        tx_beat(6, 1'b0, "inc6");
        tx_beat(7, 1'b1, "inc7");
        chk("inc_rxcnt2", 32'(rx_cnt), 32'd2);
        chk("inc_err", 32'(err_cnt), 32'd0);
        repeat (GAP) tick();
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_tvalid", 32'(tx_tvalid), 32'd0);

        // backpressure: tready 1010..., len 3
        relink(1'b0, 16'd3);
        start_en = 1'b1;
        tick();
        exp_d = 0;
        hs_n  = 0;
        for (int c = 0; c < 40; c++) begin
            tx_tready = (c % 2 == 0);
            if (c == 20) start_en = 1'b0;
            if (tx_tvalid) begin
                chk("bp_data", tx_tdata, exp_d);
                chk("bp_last", 32'(tx_tlast), 32'(exp_d % 3 == 2));
                if (tx_tready) begin
                    exp_d++;
                    hs_n++;
                end
            end
            tick();
        end
        tx_tready = 1'b1;
        chk("bp_hs_n",  32'(hs_n),    32'd9);
        chk("bp_txcnt", 32'(tx_cnt),  32'd3);
        chk("bp_rxcnt", 32'(rx_cnt),  32'd3);
        chk("bp_err",   32'(err_cnt), 32'd0);
        chk("bp_busy",  32'(busy),    32'd0);

        // PRBS with bit 0 of RX beat 5 flipped
        relink(1'b1, 16'd4);
        flip_at  = 5;
        start_en = 1'b1;
        exp_d    = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            tx_beat(exp_d, (i % 4 == 3), "prbs");
            exp_d = prbs_nx(exp_d);
            if (i == 4) chk("prbs_err_pre", 32'(err_cnt), 32'd0);
            if (i == 5) begin
                chk("prbs_err", 32'(err_cnt), 32'd1);
                chk("prbs_flag", 32'(err_flag), 32'd1);
            end
        end
        start_en = 1'b0;
        flip_at  = 999;
        chk("prbs_err_final", 32'(err_cnt), 32'd1);
        wait_idle("prbs_idle");

        // frame_len 0 behaves as 1: every beat is last
        relink(1'b0, 16'd0);
        start_en = 1'b1;
        tx_beat(0, 1'b1, "len0_a");
        tx_beat(1, 1'b1, "len0_b");
        tx_beat(2, 1'b1, "len0_c");
        start_en = 1'b0;
        wait_idle("len0_idle");
        chk("len0_rxcnt", 32'(rx_cnt),  32'd3);
        chk("len0_txcnt", 32'(tx_cnt),  32'd3);
        chk("len0_err",   32'(err_cnt), 32'd0);

        // early RX tlast at beat 2 of a len-4 frame
        relink(1'b0, 16'd4);
        early_at = 2;
        start_en = 1'b1;
        tx_beat(0, 1'b0, "early0");
        tx_beat(1, 1'b0, "early1");
        chk("early_err_pre", 32'(err_cnt), 32'd0);
        tx_beat(2, 1'b0, "early2");
        chk("early_err", 32'(err_cnt), 32'd1);
        start_en = 1'b0;
        tx_beat(3, 1'b1, "early3");
        early_at = 999;
        chk("early_err_post", 32'(err_cnt), 32'd1);
        chk("early_rxcnt", 32'(rx_cnt), 32'd2);
        chk("early_flag", 32'(err_flag), 32'd1);
        wait_idle("early_idle");

        // link drop mid-frame; clear also drops the sticky flag
        relink(1'b0, 16'd4);
        chk("clr_flag", 32'(err_flag), 32'd0);
        chk("clr_err",  32'(err_cnt),  32'd0);
        start_en = 1'b1;
        tx_beat(0, 1'b0, "drop0");
        tx_beat(1, 1'b0, "drop1");
        chk("drop_pre", 32'(tx_tvalid), 32'd1);
        ch_up = 1'b0;
        tick();
        chk("drop_tvalid", 32'(tx_tvalid), 32'd0);
        chk("drop_busy",   32'(busy),      32'd0);
        ch_up = 1'b1;
        tick();
        chk("relink_tvalid", 32'(tx_tvalid), 32'd1);
        tx_beat(0, 1'b0, "rl0");
        tx_beat(1, 1'b0, "rl1");
        tx_beat(2, 1'b0, "rl2");
        start_en = 1'b0;
        tx_beat(3, 1'b1, "rl3");
        chk("rl_err",   32'(err_cnt), 32'd0);
        chk("rl_rxcnt", 32'(rx_cnt),  32'd1);
        chk("rl_txcnt", 32'(tx_cnt),  32'd1);
        wait_idle("rl_idle");

        // saturation at 4 bits, then clear coincident with a tlast handshake
        relink(1'b0, 16'd0);
        start_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tx_beat(32'(i), 1'b1, "sat");
        end
        chk("sat_txcnt", 32'(tx_cnt), 32'd15);
        chk("sat_rxcnt", 32'(rx_cnt), 32'd15);
        for (int n = 0; n < 32 && !tx_tvalid; n++) tick();
        chk("sat_wait", 32'(tx_tvalid & tx_tlast), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_txcnt", 32'(tx_cnt),  32'd0);
        chk("clr_rxcnt", 32'(rx_cnt),  32'd0);
        chk("clr_err2",  32'(err_cnt), 32'd0);
        start_en = 1'b0;
        wait_idle("sat_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
